// File: rtl/wisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wisc_pkg : opcodes, memory-stage state encoding and width defaults          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package wisc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_store_buffer : one-entry posted write buffer with drain timeout         |
// | Only compiled with MEM_STAGE_WBUF_EN. Rev 1.0                               |
// +----------------------------------------------------------------------------+
`ifdef MEM_STAGE_WBUF_EN
module mem_store_buffer
  import wisc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign cnt_d     = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + 1'b1;
  // An ack on the final cycle still completes the drain cleanly.
  assign timeout_o = busy_q && !ack_i && (cnt_d == TMO_VAL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else if (busy_q) begin
      if (ack_i || timeout_o) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
      end
    end else if (load_i) begin
      busy_q  <= 1'b1;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      cnt_q   <= '0;
    end
  end

  assign busy_o  = busy_q;
  assign req_o   = busy_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule
`endif
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : memory-access pipeline stage (LW/SW req/ack, pass-through ALU)  |
// | Define MEM_STAGE_WBUF_EN for a one-entry posted store buffer. Rev 1.0       |
// +----------------------------------------------------------------------------+
module mem_stage
  import wisc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [3:0]        in_rd,
  input  logic              in_wr_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [3:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr_en,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        rd_q;
  logic              out_valid_q;
  logic [3:0]        out_rd_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_wr_en_q;
  logic              err_q;

  logic              accept;
  logic              is_mem;
  logic              go_access;
  logic              tmo_hit;
  logic              buf_tmo;
  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_aligned;

  assign accept       = in_valid && in_ready;
  assign is_mem       = is_mem_op(in_opcode);
  assign addr_full    = ADDR_W'(in_alu_out);
  assign addr_aligned = {addr_full[ADDR_W-1:1], 1'b0};
  assign cnt_d        = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit      = (cnt_d == TMO_VAL);

`ifdef MEM_STAGE_WBUF_EN
  logic              buf_busy;
  logic              buf_req;
  logic              buf_load;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  // Stores post into the buffer; only loads occupy the ACCESS state.
  assign buf_load  = accept && (in_opcode == OP_SW);
  assign go_access = accept && (in_opcode == OP_LW);
  assign in_ready  = (state_q == ST_IDLE) && !(buf_busy && is_mem);

  mem_store_buffer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load),
    .addr_i    (addr_aligned),
    .wdata_i   (in_store_data),
    .ack_i     (mem_ack),
    .busy_o    (buf_busy),
    .req_o     (buf_req),
    .addr_o    (buf_addr),
    .wdata_o   (buf_wdata),
    .timeout_o (buf_tmo)
  );

  assign mem_req   = req_q | buf_req;
  assign mem_we    = buf_req ? 1'b1 : we_q;
  assign mem_addr  = buf_req ? buf_addr : addr_q;
  assign mem_wdata = buf_req ? buf_wdata : wdata_q;
`else
  assign go_access = accept && is_mem;
  assign buf_tmo   = 1'b0;
  assign in_ready  = (state_q == ST_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_wr_en_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (buf_tmo) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (go_access) begin
            state_q <= ST_ACCESS;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= (in_opcode == OP_SW);
            addr_q  <= addr_aligned;
            wdata_q <= in_store_data;
            rd_q    <= in_rd;
          end else if (accept) begin
            // Pass-through op, or a posted store retiring immediately.
            out_valid_q <= 1'b1;
            out_rd_q    <= in_rd;
            out_data_q  <= is_mem ? '0 : in_alu_out;
            out_wr_en_q <= is_mem ? 1'b0 : in_wr_en;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            out_valid_q <= 1'b1;
            out_rd_q    <= rd_q;
            out_data_q  <= we_q ? '0 : mem_rdata;
            out_wr_en_q <= !we_q;
          end else begin
            cnt_q <= cnt_d;
            if (tmo_hit) begin
              state_q     <= ST_IDLE;
              req_q       <= 1'b0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              out_rd_q    <= rd_q;
              out_data_q  <= '0;
              out_wr_en_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign out_wr_en = out_wr_en_q;
  assign mem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage : self-checking bench for mem_stage (vector table + scoreboard)|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mem_stage;
  import wisc_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_alu_out;
  logic [15:0] in_store_data;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [3:0]  out_rd;
  logic [15:0] out_data;
  logic        out_wr_en;
  logic        mem_err;

  mem_stage #(.TIMEOUT_CYC(TMO), .ADDR_W(16), .DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_alu_out    (in_alu_out),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .in_wr_en      (in_wr_en),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_data      (out_data),
    .out_wr_en     (out_wr_en),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
    logic        wr;
    logic        chk_rd;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] alu;
    logic [3:0]  rd;
    logic        wr;
    logic [15:0] exp_data;
    logic [3:0]  exp_rd;
    logic        exp_wr;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] rd, input logic wr);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_alu_out    = alu;
    in_store_data = sd;
    in_rd         = rd;
    in_wr_en      = wr;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] rd, input logic [15:0] data, input logic wr, input logic chk_rd);
    exp_t e;
    e.rd = rd; e.data = data; e.wr = wr; e.chk_rd = chk_rd;
    exp_q.push_back(e);
  endtask

  // Writeback monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 out_data=%0h", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_rd) check("wb_rd", 32'(out_rd), 32'(mon_e.rd));
        check("wb_data", 32'(out_data), 32'(mon_e.data));
        check("wb_wr_en", 32'(out_wr_en), 32'(mon_e.wr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{OP_ADD,    16'h0001, 4'd1,  1'b1, 16'h0001, 4'd1,  1'b1};
    vecs[1] = '{OP_SUB,    16'hFFFF, 4'd15, 1'b1, 16'hFFFF, 4'd15, 1'b1};
    vecs[2] = '{OP_XOR,    16'hA5A5, 4'd0,  1'b0, 16'hA5A5, 4'd0,  1'b0};
    vecs[3] = '{OP_RED,    16'h0000, 4'd8,  1'b1, 16'h0000, 4'd8,  1'b1};
    vecs[4] = '{OP_SLL,    16'h8001, 4'd2,  1'b1, 16'h8001, 4'd2,  1'b1};
    vecs[5] = '{OP_SRA,    16'h7FFE, 4'd9,  1'b0, 16'h7FFE, 4'd9,  1'b0};
    vecs[6] = '{OP_ROR,    16'h3C3C, 4'd14, 1'b1, 16'h3C3C, 4'd14, 1'b1};
    vecs[7] = '{OP_PADDSB, 16'h5A5A, 4'd6,  1'b1, 16'h5A5A, 4'd6,  1'b1};

    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    in_valid = 1'b0; in_opcode = '0; in_alu_out = '0; in_store_data = '0; in_rd = '0; in_wr_en = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_mem_req",   32'(mem_req),   0);
    check("rst_mem_we",    32'(mem_we),    0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_rd",    32'(out_rd),    0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_wr_en", 32'(out_wr_en), 0);
    check("rst_mem_err",   32'(mem_err),   0);
    rst = 1'b1;
    tick();

    drive(OP_ADD, 16'h1234, 16'h0000, 4'd3, 1'b1);
    push(4'd3, 16'h1234, 1'b1, 1'b1);
    tick();
    idle_in();
    check("add_latency_valid", 32'(out_valid), 1);
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].alu, 16'hDEAD, vecs[i].rd, vecs[i].wr);
      check("tbl_in_ready", 32'(in_ready), 1);
      push(vecs[i].exp_rd, vecs[i].exp_data, vecs[i].exp_wr, 1'b1);
      tick();
    end
    idle_in();
    tick(); tick();
    check("tbl_drained", 32'(exp_q.size()), 0);

    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_req", 32'(mem_req), 0);
    tick();

    drive(OP_LW, 16'h0041, 16'h9999, 4'd7, 1'b0);
    push(4'd7, 16'hBEEF, 1'b1, 1'b1);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      check("lw_req",      32'(mem_req),  1);
      check("lw_in_ready", 32'(in_ready), 0);
      check("lw_addr",     32'(mem_addr), 32'h0040);
      check("lw_we",       32'(mem_we),   0);
      tick();
    end
    check("lw_req_before_ack", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("lw_out_valid", 32'(out_valid), 1);
    check("lw_req_drop",  32'(mem_req),   0);
    check("lw_ready_back", 32'(in_ready), 1);
    tick();

`ifndef MEM_STAGE_WBUF_EN
    drive(OP_SW, 16'h0010, 16'h00AA, 4'd5, 1'b1);
    push(4'd5, 16'h0000, 1'b0, 1'b0);
    tick();
    idle_in();
    check("sw_req",      32'(mem_req),   1);
    check("sw_we",       32'(mem_we),    1);
    check("sw_wdata",    32'(mem_wdata), 32'h00AA);
    check("sw_addr",     32'(mem_addr),  32'h0010);
    check("sw_in_ready", 32'(in_ready),  0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sw_out_valid", 32'(out_valid), 1);
    check("sw_req_drop",  32'(mem_req),   0);
    tick();
`else
    drive(OP_SW, 16'h0020, 16'h5555, 4'd2, 1'b1);
    check("wb_sw_ready", 32'(in_ready), 1);
    push(4'd2, 16'h0000, 1'b0, 1'b0);
    tick();
    check("wb_sw_record", 32'(out_valid), 1);
    check("wb_drain_req", 32'(mem_req),   1);
    check("wb_drain_we",  32'(mem_we),    1);
    check("wb_drain_addr", 32'(mem_addr), 32'h0020);
    check("wb_drain_wdata", 32'(mem_wdata), 32'h5555);
    drive(OP_XOR, 16'h0F0F, 16'h0000, 4'd4, 1'b1);
    check("wb_xor_ready", 32'(in_ready), 1);
    push(4'd4, 16'h0F0F, 1'b1, 1'b1);
    tick();
    drive(OP_LW, 16'h0031, 16'h0000, 4'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("wb_lw_stalled", 32'(in_ready), 0);
      tick();
    end
    check("wb_lw_stalled", 32'(in_ready), 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("wb_drain_done", 32'(mem_req),  0);
    check("wb_lw_ready",   32'(in_ready), 1);
    push(4'd6, 16'h7777, 1'b1, 1'b1);
    tick();
    idle_in();
    check("wb_lw_req",  32'(mem_req),  1);
    check("wb_lw_we",   32'(mem_we),   0);
    check("wb_lw_addr", 32'(mem_addr), 32'h0030);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    tick();
`endif

    // Ack arriving on the very last cycle before timeout must win.
    drive(OP_LW, 16'h0101, 16'h0000, 4'd9, 1'b0);
    push(4'd9, 16'hCAFE, 1'b1, 1'b1);
    tick();
    idle_in();
    repeat (TMO - 1) tick();
    check("late_ack_req", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    check("late_ack_no_err", 32'(mem_err), 0);
    check("late_ack_req_drop", 32'(mem_req), 0);
    tick();

    drive(OP_LW, 16'h0200, 16'h0000, 4'd10, 1'b0);
    push(4'd10, 16'h0000, 1'b0, 1'b0);
    tick();
    idle_in();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("tmo_req_cycles", 32'(n), TMO);
    check("tmo_err",        32'(mem_err),   1);
    check("tmo_out_valid",  32'(out_valid), 1);
    tick();
    drive(OP_ADD, 16'h4321, 16'h0000, 4'd1, 1'b1);
    push(4'd1, 16'h4321, 1'b1, 1'b1);
    tick();
    idle_in();
    check("tmo_err_sticky", 32'(mem_err), 1);
    tick();

    drive(OP_LW, 16'h0300, 16'h0000, 4'd11, 1'b0);
    tick();
    idle_in();
    tick();
    check("rstmid_req_before", 32'(mem_req), 1);
    rst = 1'b0;
    tick();
    check("rstmid_req",   32'(mem_req),   0);
    check("rstmid_err",   32'(mem_err),   0);
    check("rstmid_valid", 32'(out_valid), 0);
    rst = 1'b1;
    repeat (3) tick();
    check("rstmid_ready", 32'(in_ready), 1);

    drive(OP_ADD, 16'h0F0F, 16'h0000, 4'd2, 1'b0);
    push(4'd2, 16'h0F0F, 1'b0, 1'b1);
    tick();
    idle_in();
    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the ALU in the 16-bit pipeline. It consumes the ALU result, opcode, store data and destination register. LW/SW become a request/acknowledge transaction on the data-memory port; all other opcodes pass straight through. It emits one writeback record per accepted instruction, stalling upstream via `in_ready` while a memory access is outstanding.

## Interface
- `TIMEOUT_CYC`, 255: max cycles a request may wait for `mem_ack` before it is aborted.
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: data width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: upstream record valid.
- `in_ready` out 1: stage can accept a record this cycle.
- `in_opcode` in 4: instruction opcode. LW = 4'b1000, SW = 4'b1001.
- `in_alu_out` in DATA_W: ALU result, or effective address for LW/SW.
- `in_store_data` in DATA_W: SW data.
- `in_rd` in 4: destination register.
- `in_wr_en` in 1: register write request for non-memory ops.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: word address, bit 0 forced to 0.
- `mem_wdata` out DATA_W: write data.
- `mem_ack` in 1: one-cycle completion strobe.
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`.
- `out_valid` out 1: one-cycle writeback strobe.
- `out_rd` out 4: writeback register.
- `out_data` out DATA_W: writeback data.
- `out_wr_en` out 1: writeback enable.
- `mem_err` out 1: sticky timeout error.

## Operation
- **States:** IDLE, ACCESS.
- **Acceptance:** a record is accepted when `in_valid && in_ready`. `in_ready` = (state == IDLE), subject to the write-buffer rule in Configuration.
- **IDLE, non-memory opcode accepted:**
  - Next cycle: `out_valid`=1, `out_data`=`in_alu_out`, `out_rd`=`in_rd`, `out_wr_en`=`in_wr_en`.
  - State stays IDLE.
- **IDLE, LW/SW accepted:**
  - Latch `mem_addr`={`in_alu_out[15:1]`,0}, `mem_wdata`=`in_store_data`, `mem_we`=(opcode==SW), `in_rd`.
  - Next state ACCESS; the timeout counter is cleared.
- **ACCESS:**
  - `mem_req`=1, with address, write data and `mem_we` held stable.
  - The counter increments every cycle without an ack.
- **Ack received in ACCESS:**
  - LW: `out_valid`=1, `out_data`=`mem_rdata`, `out_wr_en`=1.
  - SW: `out_valid`=1, `out_data`=0, `out_wr_en`=0.
  - Next state IDLE.
- **Timeout:** the counter reaches `TIMEOUT_CYC` with no ack. Then:
  - `mem_req` drops.
  - `mem_err` is set (sticky until reset).
  - `out_valid`=1, `out_data`=16'h0000, `out_wr_en`=0.
  - Next state IDLE.
- **Ack and timeout in the same cycle:** the ack wins; no error.
- **Stray ack:** `mem_ack` while `mem_req`=0 is ignored.
- **Counter width:** the counter is wide enough for `TIMEOUT_CYC`, saturates, and never wraps.

## Timing
- **Reset values:** `in_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `out_valid`=0, `out_rd`=0, `out_data`=0, `out_wr_en`=0, `mem_err`=0. State = IDLE, buffer empty.
- **Non-memory latency:** 1 cycle. Back-to-back issue is possible every cycle.
- **Memory latency:**
  - Accepted at edge t → `mem_req` high from t+1.
  - `mem_ack` sampled at edge t+k → `out_valid` at t+k+1.
  - `mem_req` low at t+k+1.
  - Minimum load-use occupancy: 3 cycles.
- **`out_valid`:** high exactly one cycle per accepted record. Records are never dropped or duplicated.
- **Reset mid-access:** the request is abandoned, `mem_req`=0 after the edge, no `out_valid` is produced for it, and the buffer is cleared.

## Configuration
- **`MEM_STAGE_WBUF_EN` defined:** one-entry posted write buffer.
  - An SW accepted in IDLE with the buffer empty loads the buffer and produces its writeback record (`out_wr_en`=0) next cycle.
  - The stage stays IDLE; the buffer drains via `mem_req` in the background, with the same timeout rule.
  - While the buffer is occupied, non-memory ops are accepted normally.
  - LW/SW see `in_ready`=0 until the drain ack (or timeout).
- **`MEM_STAGE_WBUF_EN` undefined:** SW behaves exactly like LW timing, waiting in ACCESS for the ack.

## Structure
- **Shared package `wisc_pkg`:**
  - Opcode constants (LW, SW, alongside the existing ALU opcodes).
  - State encoding for IDLE/ACCESS.
  - `DATA_W`/`ADDR_W` defaults.
- **Sub-module `mem_store_buffer`:** one-entry write buffer with its own drain request and timeout. It is instantiated only under `MEM_STAGE_WBUF_EN`.

## Test plan
- **Reset:** reset, then ADD record with `in_alu_out`=16'h1234, `in_rd`=3, `in_wr_en`=1 → `out_valid` 1 cycle later; `out_data`=16'h1234, `out_rd`=3, `out_wr_en`=1.
- **LW:** LW with `in_alu_out`=16'h0041, `mem_ack` 4 cycles after `mem_req` with `mem_rdata`=16'hBEEF → `mem_addr`=16'h0040, `mem_we`=0, `in_ready`=0 throughout, `out_data`=16'hBEEF, `out_wr_en`=1.
- **SW, buffer disabled:** SW with address 16'h0010 and data 16'h00AA → `mem_we`=1, `mem_wdata`=16'h00AA; `out_wr_en`=0 after the ack.
- **Timeout:** LW with no ack and `TIMEOUT_CYC`=8 → `mem_req` drops after 8 cycles, `mem_err`=1, `out_data`=0, `out_wr_en`=0; the next ADD completes normally.
- **Buffer enabled:** SW, then XOR, then LW with ack delayed 5 cycles → SW record at +1, XOR accepted at +1, LW stalled until the drain ack.
- **Reset mid-access:** `rst`=0 during ACCESS → `mem_req`=0 next cycle and no `out_valid` follows.
